// File: rtl/zapper_pkg.sv
// Shared types and helpers for the multi-gun zapper arbiter.
// Holds the controller state encoding, the gun index width and the round-robin pick.
package zapper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WINDOW = 2'd2,
    REPORT = 2'd3
  } state_t;

  function automatic int gun_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set request searching from last+1 with wrap; returns last when nothing is set.
  function automatic int rr_next(input logic [7:0] req, input int last, input int n);
    int idx;
    bit found;
    rr_next = last;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = (last + k) % n;
      if (k <= n && !found && req[idx[2:0]]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/zapper_sync.sv
// Multi-flop synchroniser for one asynchronous gun input.
// EDGE selects a registered rising-edge pulse output instead of the synchronised level.
module zapper_sync #(
  parameter int STAGES = 2,
  parameter bit EDGE   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic rise_reg;
      // Pulse lines up with the cycle in which the last stage first reads high.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rise_reg <= 1'b0;
        end else begin
          rise_reg <= sync_reg[STAGES-2] & ~sync_reg[STAGES-1];
        end
      end
      assign q = rise_reg;
    end else begin : g_level
      assign q = sync_reg[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/zapper_arbiter.sv
// Light-gun controller: queues trigger pulls from N_GUNS zappers and grants the shared
// flash window round-robin, reporting one hit/miss result per granted shot.
module zapper_arbiter
  import zapper_pkg::*;
#(
  parameter int  N_GUNS        = 2,
  parameter int  HOLD_CYCLES   = 50000000,
  parameter int  SETTLE_CYCLES = 2,
  parameter int  SYNC_STAGES   = 2,
  localparam int GUN_W         = gun_w(N_GUNS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_GUNS-1:0] trigger,
  input  logic [N_GUNS-1:0] detect,
  output logic              flash,
  output logic              busy,
  output logic [GUN_W-1:0]  active_gun,
  output logic              result_valid,
  output logic              result_hit,
  output logic [GUN_W-1:0]  result_gun,
  output logic [N_GUNS-1:0] pending
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [GUN_W-1:0]   active_reg, active_next;
  logic [GUN_W-1:0]   last_reg, last_next;
  logic [GUN_W-1:0]   result_gun_reg, result_gun_next;
  logic               hit_reg, hit_next;
  logic [N_GUNS-1:0]  pending_reg, pending_next;
  logic               flash_reg, busy_reg, valid_reg;

  logic [N_GUNS-1:0]  trig_rise;
  logic [N_GUNS-1:0]  det_sync;
  logic [N_GUNS-1:0]  set_mask;
  logic [GUN_W-1:0]   grant_gun;

  generate
    for (genvar gi = 0; gi < N_GUNS; gi++) begin : g_gun
      zapper_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trigger[gi]),
        .q     (trig_rise[gi])
      );
      zapper_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_det_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (detect[gi]),
        .q     (det_sync[gi])
      );
      // A pull from the gun that currently owns the window is discarded.
      assign set_mask[gi] = trig_rise[gi] &
                            ~((state_reg != IDLE) && (active_reg == GUN_W'(gi)));
    end
  endgenerate

  assign grant_gun = GUN_W'(rr_next(8'(pending_reg), int'(last_reg), N_GUNS));

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    active_next     = active_reg;
    last_next       = last_reg;
    result_gun_next = result_gun_reg;
    hit_next        = hit_reg;
    pending_next    = pending_reg | set_mask;

    case (state_reg)
      IDLE: begin
        if (|pending_reg) begin
          // Clearing after the set merge drops a same-cycle edge from the granted gun.
          pending_next[grant_gun] = 1'b0;
          active_next             = grant_gun;
          count_next              = CNT_W'(1);
          state_next              = SETTLE;
        end
      end
      SETTLE: begin
        count_next = count_reg + 1'b1;
        if (count_reg >= CNT_W'(SETTLE_CYCLES)) begin
          state_next = WINDOW;
        end
      end
      WINDOW: begin
        if (det_sync[active_reg]) begin
          hit_next        = 1'b1;
          result_gun_next = active_reg;
          state_next      = REPORT;
        end else if (count_reg == CNT_W'(HOLD_CYCLES)) begin
          hit_next        = 1'b0;
          result_gun_next = active_reg;
          state_next      = REPORT;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      REPORT: begin
        last_next  = active_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      active_reg     <= '0;
      last_reg       <= GUN_W'(N_GUNS - 1);
      result_gun_reg <= '0;
      hit_reg        <= 1'b0;
      pending_reg    <= '0;
      flash_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      active_reg     <= active_next;
      last_reg       <= last_next;
      result_gun_reg <= result_gun_next;
      hit_reg        <= hit_next;
      pending_reg    <= pending_next;
      flash_reg      <= (state_next == SETTLE) || (state_next == WINDOW);
      busy_reg       <= (state_next != IDLE);
      valid_reg      <= (state_next == REPORT);
    end
  end

  assign flash        = flash_reg;
  assign busy         = busy_reg;
  assign active_gun   = active_reg;
  assign result_valid = valid_reg;
  assign result_hit   = hit_reg;
  assign result_gun   = result_gun_reg;
  assign pending      = pending_reg;

endmodule

// File: tb/tb_zapper_arbiter.sv
// Directed bench for zapper_arbiter with two guns, a 16-cycle window and 2 settle cycles.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_zapper_arbiter;

  localparam int N_GUNS = 2;
  localparam int HOLD   = 16;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] trigger = 2'b00;
  logic [1:0] detect = 2'b00;
  logic       flash, busy, result_valid, result_hit;
  logic [0:0] active_gun, result_gun;
  logic [1:0] pending;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  zapper_arbiter #(
    .N_GUNS        (N_GUNS),
    .HOLD_CYCLES   (HOLD),
    .SETTLE_CYCLES (SETTLE),
    .SYNC_STAGES   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger      (trigger),
    .detect       (detect),
    .flash        (flash),
    .busy         (busy),
    .active_gun   (active_gun),
    .result_valid (result_valid),
    .result_hit   (result_hit),
    .result_gun   (result_gun),
    .pending      (pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a falling edge; the pending bit appears on the third falling edge after.
  task automatic pull(input string tag, input logic [1:0] mask,
                      input logic [1:0] exp_before, input logic [1:0] exp_after);
    trigger = trigger | mask;
    @(negedge clk);
    @(negedge clk);
    check({tag, " pending_early"}, 32'(pending), 32'(exp_before));
    @(negedge clk);
    check({tag, " pending"}, 32'(pending), 32'(exp_after));
    trigger = trigger & ~mask;
    $display("[TB] %s: trigger mask=%b pending=%b", tag, mask, pending);
  endtask

  // Waits for the window, drives detect on flash-high cycle det_on (cleared on det_off),
  // measures the flash length and checks the single result pulse that follows.
  task automatic shot(input string tag, input int det_on, input int det_off, input int gun,
                      input int exp_len, input int exp_hit, input logic [1:0] exp_pend,
                      output int wait_n);
    int len;
    bit started;
    started = 1'b0;
    wait_n  = 0;
    len     = 0;
    while (!started && wait_n < 100) begin
      @(negedge clk);
      if (flash === 1'b1) started = 1'b1;
      else wait_n++;
    end
    check({tag, " start"}, 32'(started), 32'd1);
    if (started) begin
      check({tag, " active_gun"}, 32'(active_gun), 32'(gun));
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " pending_at_grant"}, 32'(pending), 32'(exp_pend));
      len = 1;
      while (len <= HOLD + 4) begin
        if (len == det_on) detect[gun[0]] = 1'b1;
        if (len == det_off) detect[gun[0]] = 1'b0;
        @(negedge clk);
        if (flash === 1'b1) len++;
        else break;
      end
      check({tag, " flash_len"}, 32'(len), 32'(exp_len));
      check({tag, " result_valid"}, 32'(result_valid), 32'd1);
      check({tag, " result_hit"}, 32'(result_hit), 32'(exp_hit));
      check({tag, " result_gun"}, 32'(result_gun), 32'(gun));
      $display("[TB] %s: gun=%0d flash_len=%0d hit=%0d", tag, result_gun, len, result_hit);
      @(negedge clk);
      check({tag, " result_valid_one_cycle"}, 32'(result_valid), 32'd0);
    end
    detect = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;
    int j;
    int n;
    int rv_count;
    bit ok;

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trigger = 2'($urandom_range(0, 3));
      detect  = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    check("reset flash", 32'(flash), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result_valid", 32'(result_valid), 32'd0);
    check("reset result_hit", 32'(result_hit), 32'd0);
    check("reset active_gun", 32'(active_gun), 32'd0);
    check("reset result_gun", 32'(result_gun), 32'd0);
    check("reset pending", 32'(pending), 32'd0);
    $display("[TB] reset: flash=%b busy=%b pending=%b", flash, busy, pending);
    trigger = 2'b00;
    detect  = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset busy", 32'(busy), 32'd0);
    check("post_reset pending", 32'(pending), 32'd0);

    // Gun 0 hit: synchronised detect lands in window cycle 6 -> flash 2+6
    pull("g0_hit", 2'b01, 2'b00, 2'b01);
    shot("g0_hit", 6, 0, 0, SETTLE + 6, 1, 2'b00, gap);
    check("g0_hit grant_latency", 32'(gap), 32'd0);
    repeat (3) @(negedge clk);

    // Gun 1 miss: full window
    pull("g1_miss", 2'b10, 2'b00, 2'b10);
    shot("g1_miss", 0, 0, 1, HOLD, 0, 2'b00, gap);
    repeat (3) @(negedge clk);

    // Simultaneous triggers from a fresh reset: gun 0 first, then gun 1
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pull("both", 2'b11, 2'b00, 2'b11);
    shot("both_first", 0, 0, 0, HOLD, 0, 2'b10, gap);
    // REPORT and one IDLE cycle were consumed by the previous shot, so flash rises next.
    shot("both_second", 0, 0, 1, HOLD, 0, 2'b00, gap);
    check("both idle_gap", 32'(gap), 32'd0);
    repeat (3) @(negedge clk);

    // Detect seen only in SETTLE cycles must be ignored
    trigger = 2'b01;
    @(negedge clk);
    @(negedge clk);
    detect = 2'b01;
    shot("settle_det", 0, 1, 0, HOLD, 0, 2'b00, gap);
    check("settle_det grant_latency", 32'(gap), 32'd1);
    trigger = 2'b00;
    repeat (3) @(negedge clk);

    // Mid-window reset with gun 1 queued; a re-pull from gun 0 is dropped
    pull("midrst", 2'b01, 2'b00, 2'b01);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (flash === 1'b1) ok = 1'b1;
      else n++;
    end
    check("midrst start", 32'(ok), 32'd1);
    j = 1;
    while (j < SETTLE + 5) begin
      if (j == 2) trigger = 2'b11;
      @(negedge clk);
      j++;
    end
    check("midrst flash_before", 32'(flash), 32'd1);
    check("midrst pending_before", 32'(pending), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst flash_async", 32'(flash), 32'd0);
    check("midrst busy_async", 32'(busy), 32'd0);
    check("midrst pending_async", 32'(pending), 32'd0);
    check("midrst valid_async", 32'(result_valid), 32'd0);
    $display("[TB] midrst: flash=%b busy=%b pending=%b", flash, busy, pending);
    trigger = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_count = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) rv_count++;
    end
    check("midrst no_result", 32'(rv_count), 32'd0);
    check("midrst idle_busy", 32'(busy), 32'd0);
    check("midrst idle_pending", 32'(pending), 32'd0);
    check("midrst idle_flash", 32'(flash), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
